brcmp_unit: RTL and testbench

Two-stage pipelined compare unit that resolves RISC-V branch conditions, SLT/SLTU results and, optionally, Zbb min/max results from two 32-bit operands. It sits directly downstream of the operand/register-read path and is the consumer and wrapper of the team's 32-bit magnitude comparator, instantiating it once. It turns raw GT/LT/EQ flags into architectural results behind a valid/ready handshake with flush.

---
 rtl/brcmp_pkg.sv | 27 ++
 rtl/magcompare32.sv | 15 +
 rtl/brcmp_unit.sv | 149 ++++++++++++++
 tb/tb_brcmp_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brcmp_pkg.sv
// brcmp_pkg: op codes and constants shared by the branch/compare unit.
// Min/max op codes are only legal when BRCMP_MINMAX_EN is defined.
package brcmp_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_BEQ  = 4'b0000;
  localparam op_t OP_BNE  = 4'b0001;
  localparam op_t OP_BLT  = 4'b0100;
  localparam op_t OP_BGE  = 4'b0101;
  localparam op_t OP_BLTU = 4'b0110;
  localparam op_t OP_BGEU = 4'b0111;
  localparam op_t OP_SLT  = 4'b1010;
  localparam op_t OP_SLTU = 4'b1011;
  localparam op_t OP_MIN  = 4'b1100;
  localparam op_t OP_MAX  = 4'b1101;
  localparam op_t OP_MINU = 4'b1110;
  localparam op_t OP_MAXU = 4'b1111;

  localparam logic [31:0] SIGN_BIAS = 32'h8000_0000;

  // Flipping bit 31 maps two's-complement order onto unsigned order.
  function automatic logic op_signed(op_t op);
    return op inside {OP_BLT, OP_BGE, OP_SLT, OP_MIN, OP_MAX};
  endfunction

endpackage

// File: rtl/magcompare32.sv
// magcompare32: 32-bit unsigned magnitude comparator.
// Exactly one of gt/lt/eq is high for any operand pair.
module magcompare32 (
  output logic        gt,
  output logic        lt,
  output logic        eq,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  assign gt = a > b;
  assign lt = a < b;
  assign eq = a == b;

endmodule

// File: rtl/brcmp_unit.sv
// brcmp_unit: two-stage branch/SLT/min-max resolver with valid/ready.
// Define BRCMP_MINMAX_EN to make MIN/MAX/MINU/MAXU legal.
module brcmp_unit
  import brcmp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic [31:0] out_result,
  output logic        out_illegal
);

  logic        s1_valid_q, s1_valid_d;
  op_t         s1_op_q, s1_op_d;
  logic [31:0] s1_a_q, s1_a_d;
  logic [31:0] s1_b_q, s1_b_d;

  logic        out_valid_q, out_valid_d;
  logic        out_taken_q, out_taken_d;
  logic [31:0] out_result_q, out_result_d;
  logic        out_illegal_q, out_illegal_d;

  logic        s2_adv;
  logic        in_fire;
  logic [31:0] cmp_a, cmp_b;
  logic        gt, lt, eq;
  logic        is_br, is_set;
  logic        res_taken, res_illegal;
  logic [31:0] res_result;

  assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~reset & ~flush & (~s1_valid_q | s2_adv);
  assign in_fire  = in_valid & in_ready;

  assign cmp_a = op_signed(s1_op_q) ? (s1_a_q ^ SIGN_BIAS) : s1_a_q;
  assign cmp_b = op_signed(s1_op_q) ? (s1_b_q ^ SIGN_BIAS) : s1_b_q;

  magcompare32 u_cmp (
    .gt (gt),
    .lt (lt),
    .eq (eq),
    .a  (cmp_a),
    .b  (cmp_b)
  );

  assign is_br = s1_op_q inside {OP_BEQ, OP_BNE, OP_BLT,
                                 OP_BGE, OP_BLTU, OP_BGEU};
  assign is_set = s1_op_q inside {OP_SLT, OP_SLTU};

`ifdef BRCMP_MINMAX_EN
  logic is_mm;
  assign is_mm = s1_op_q[3:2] == 2'b11;
`endif

  always_comb begin
    res_taken   = 1'b0;
    res_result  = '0;
    res_illegal = 1'b0;
    unique case (1'b1)
      is_br: begin
        case (s1_op_q)
          OP_BEQ:          res_taken = eq;
          OP_BNE:          res_taken = ~eq;
          OP_BLT, OP_BLTU: res_taken = lt;
          default:         res_taken = ~lt;
        endcase
      end
      is_set: res_result = {31'b0, lt};
`ifdef BRCMP_MINMAX_EN
      // op[0] distinguishes MAX (pick a on GT) from MIN (pick a on LT).
      is_mm: begin
        if (s1_op_q[0]) res_result = gt ? s1_a_q : s1_b_q;
        else            res_result = lt ? s1_a_q : s1_b_q;
      end
`endif
      default: res_illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_op_d       = s1_op_q;
    s1_a_d        = s1_a_q;
    s1_b_d        = s1_b_q;
    out_valid_d   = out_valid_q;
    out_taken_d   = out_taken_q;
    out_result_d  = out_result_q;
    out_illegal_d = out_illegal_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d   = 1'b1;
      out_taken_d   = res_taken;
      out_result_d  = res_result;
      out_illegal_d = res_illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_result_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_op_q       <= s1_op_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      out_valid_q   <= out_valid_d;
      out_taken_q   <= out_taken_d;
      out_result_q  <= out_result_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_taken   = out_taken_q;
  assign out_result  = out_result_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_brcmp_unit.sv
// tb_brcmp_unit: scoreboard bench for brcmp_unit.
// Min/max expectations follow BRCMP_MINMAX_EN.
module tb_brcmp_unit;
  import brcmp_pkg::*;

  typedef struct packed {
    logic        taken;
    logic [31:0] result;
    logic        illegal;
  } res_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_result;
  logic        out_illegal;

  int n_assert = 0;
  int n_fail   = 0;
  int n_in     = 0;

  res_t exp_q[$];
  res_t want_q[$];
  res_t got_q[$];

  brcmp_unit dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_taken   (out_taken),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    res_t r;
    logic slt, ult;
    r = '0;
    slt = $signed(a) < $signed(b);
    ult = a < b;
    case (op)
      4'b0000: r.taken = (a == b);
      4'b0001: r.taken = (a != b);
      4'b0100: r.taken = slt;
      4'b0101: r.taken = !slt;
      4'b0110: r.taken = ult;
      4'b0111: r.taken = !ult;
      4'b1010: r.result = {31'b0, slt};
      4'b1011: r.result = {31'b0, ult};
`ifdef BRCMP_MINMAX_EN
      4'b1100: r.result = slt ? a : b;
      4'b1101: r.result = ($signed(a) > $signed(b)) ? a : b;
      4'b1110: r.result = ult ? a : b;
      4'b1111: r.result = (a > b) ? a : b;
`endif
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  // One clock: record output transfers and accepted inputs, then advance.
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      got_q.push_back({out_taken, out_result, out_illegal});
      if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
      else want_q.push_back('x);
    end
    if (reset || flush) exp_q.delete();
    else if (in_valid && in_ready) begin
      exp_q.push_back(model(in_op, in_a, in_b));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    want_q.delete();
    got_q.delete();
    n_in = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_assert++;
    if ({out_valid, out_taken, out_result, out_illegal, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b t=%b r=%h i=%b rdy=%b, want all 0",
               out_valid, out_taken, out_result, out_illegal, in_ready);
    end
    reset = 1'b0;
    #1;
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_branch_set();
    logic [3:0] ops[3];
    logic [31:0] as[3];
    logic [31:0] bs[3];
    int guard;
    ops = '{OP_BLTU, OP_SLTU, OP_SLT};
    as  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    bs  = '{32'h0000_0001, 32'd5, 32'd0};
    clear_sb();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_BLT; in_a = 32'hFFFF_FFFF; in_b = 32'd1;
    tick();
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL blt_latency_early: out_valid=%b want 0", out_valid);
    end
    tick();
    n_assert++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL blt_taken: v=%b t=%b want v=1 t=1", out_valid, out_taken);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = ops[i]; in_a = as[i]; in_b = bs[i];
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_assert++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL directed_count: got %0d want 4", got_q.size());
    end else begin
      n_assert++;
      if (got_q[1].taken !== 1'b0) begin
        n_fail++;
        $display("FAIL bltu_taken: got %b want 0", got_q[1].taken);
      end
      n_assert++;
      if (got_q[2].result !== 32'd0) begin
        n_fail++;
        $display("FAIL sltu_eq: got %h want 0", got_q[2].result);
      end
      n_assert++;
      if (got_q[3].result !== 32'd1) begin
        n_fail++;
        $display("FAIL slt_neg: got %h want 1", got_q[3].result);
      end
    end
    // Random ops with random backpressure.
    for (int c = 0; c < 60; c++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_op     = 4'($urandom);
      in_a      = $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      if ($urandom_range(0, 3) == 0) in_a = in_a ^ SIGN_BIAS;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() > 0 || out_valid) && guard < 10) begin
      tick();
      guard++;
    end
    n_assert++;
    if (exp_q.size() != 0 || got_q.size() != n_in) begin
      n_fail++;
      $display("FAIL rand_drain: outputs=%0d want %0d pending=%0d",
               got_q.size(), n_in, exp_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_assert++;
      if (got_q[i] !== want_q[i]) begin
        n_fail++;
        $display("FAIL sb[%0d]: got t=%b r=%h i=%b want t=%b r=%h i=%b", i,
                 got_q[i].taken, got_q[i].result, got_q[i].illegal,
                 want_q[i].taken, want_q[i].result, want_q[i].illegal);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[3];
    logic [31:0] as[3];
    logic [31:0] bs[3];
    logic fire;
    res_t snap;
    int idx;
    int guard;
    ops = '{OP_BEQ, OP_BNE, OP_BGE};
    as  = '{32'd7, 32'd7, 32'd3};
    bs  = '{32'd7, 32'd7, 32'd9};
    clear_sb();
    snap = '0;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
      #1;
      fire = in_ready;
      tick();
      if (fire) idx++;
      if (c == 1) snap = {out_taken, out_result, out_illegal};
    end
    n_assert++;
    if (idx != 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_fill: accepts=%0d rdy=%b want 2 and 0", idx, in_ready);
    end
    n_assert++;
    if (out_valid !== 1'b1 || {out_taken, out_result, out_illegal} !== snap) begin
      n_fail++;
      $display("FAIL b2b_hold: v=%b t=%b r=%h want v=1 t=%b r=%h", out_valid,
               out_taken, out_result, snap.taken, snap.result);
    end
    out_ready = 1'b1;
    guard = 0;
    while ((idx < 3 || exp_q.size() > 0) && guard < 12) begin
      if (idx < 3) begin
        in_valid = 1'b1; in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
      end else in_valid = 1'b0;
      #1;
      fire = in_valid && in_ready;
      tick();
      if (fire) idx++;
      guard++;
    end
    in_valid = 1'b0;
    tick();
    n_assert++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 3", got_q.size());
    end else begin
      n_assert++;
      if ({got_q[0].taken, got_q[1].taken, got_q[2].taken} !== 3'b100) begin
        n_fail++;
        $display("FAIL b2b_order: got %b%b%b want 100", got_q[0].taken,
                 got_q[1].taken, got_q[2].taken);
      end
      for (int i = 0; i < 3; i++) begin
        n_assert++;
        if (got_q[i] !== want_q[i]) begin
          n_fail++;
          $display("FAIL b2b_sb[%0d]: got t=%b r=%h want t=%b r=%h", i,
                   got_q[i].taken, got_q[i].result, want_q[i].taken, want_q[i].result);
        end
      end
    end
  endtask

  task automatic test_flush();
    int acc;
    clear_sb();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_BEQ; in_a = 32'd1; in_b = 32'd1;
    tick();
    in_op = OP_SLTU; in_a = 32'd1; in_b = 32'd2;
    tick();
    acc = n_in;
    in_op = OP_BNE; in_a = 32'd4; in_b = 32'd5;
    flush = 1'b1;
    #1;
    n_assert++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0 || acc != 2 || n_in != 2) begin
      n_fail++;
      $display("FAIL flush_kill: v=%b accepts=%0d want v=0 accepts=2", out_valid, n_in);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_assert++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL flush_leak: outputs=%0d want 0", got_q.size());
    end
  endtask

  task automatic test_minmax();
    res_t want_min, want_maxu;
`ifdef BRCMP_MINMAX_EN
    want_min  = {1'b0, 32'hFFFF_FFFE, 1'b0};
    want_maxu = {1'b0, 32'hFFFF_FFFE, 1'b0};
`else
    want_min  = {1'b0, 32'h0, 1'b1};
    want_maxu = {1'b0, 32'h0, 1'b1};
`endif
    clear_sb();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_MIN; in_a = 32'hFFFF_FFFE; in_b = 32'd3;
    tick();
    in_op = OP_MAXU;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_assert++;
    if (got_q.size() != 2) begin
      n_fail++;
      $display("FAIL mm_count: got %0d want 2", got_q.size());
    end else begin
      n_assert++;
      if (got_q[0] !== want_min) begin
        n_fail++;
        $display("FAIL min_neg: got r=%h i=%b want r=%h i=%b", got_q[0].result,
                 got_q[0].illegal, want_min.result, want_min.illegal);
      end
      n_assert++;
      if (got_q[1] !== want_maxu) begin
        n_fail++;
        $display("FAIL maxu_neg: got r=%h i=%b want r=%h i=%b", got_q[1].result,
                 got_q[1].illegal, want_maxu.result, want_maxu.illegal);
      end
    end
  endtask

  task automatic test_reset_midop();
    clear_sb();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_BEQ; in_a = 32'd9; in_b = 32'd9;
    tick();
    in_op = OP_SLTU; in_a = 32'd0; in_b = 32'd1;
    tick();
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_fill: v=%b t=%b want 1 1", out_valid, out_taken);
    end
    reset = 1'b1;
    tick();
    n_assert++;
    if ({out_valid, out_taken, out_result, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: v=%b t=%b r=%h i=%b want all 0",
               out_valid, out_taken, out_result, out_illegal);
    end
    reset = 1'b0;
    #1;
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_assert++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL midop_leak: outputs=%0d want 0", got_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    test_reset();
    test_branch_set();
    test_back_to_back();
    test_flush();
    test_minmax();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
